// File: rtl/shift_right_iterative_pkg.sv
// Shared encodings for the iterative shifter: operation modes (also used by the
// ALU control decoder) and the controller state encoding.
package shift_right_iterative_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        MODE_SRL  = 2'b00,
        MODE_SRA  = 2'b01,
        MODE_ROTR = 2'b10,
        MODE_SLL  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Bits to shift this cycle: the whole remainder once it fits in one step.
    function automatic logic [SHAMT_W-1:0] step_amount(
        input logic [SHAMT_W-1:0] remaining,
        input int                 step
    );
        logic [SHAMT_W-1:0] step_w;
        step_w = SHAMT_W'(step);
        return (remaining < step_w) ? remaining : step_w;
    endfunction

endpackage

// File: rtl/shift_right_iterative_shift_step.sv
// Combinational single-step shifter: shifts a word by k (0..STEP) positions
// in the selected mode. SRA fills with the sign of the original operand.
module shift_step
    import shift_right_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [KW-1:0]    k,
    input  mode_e            mode,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    // One constant-distance candidate per legal k; the mux below picks one.
    logic [STEP:0][WIDTH-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi <= STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_pass
                assign cand[gi] = word;
            end else begin : g_shift
                assign cand[gi] =
                    (mode == MODE_SRL)  ? {{gi{1'b0}}, word[WIDTH-1:gi]} :
                    (mode == MODE_SRA)  ? {{gi{sign}}, word[WIDTH-1:gi]} :
                    (mode == MODE_ROTR) ? {word[gi-1:0], word[WIDTH-1:gi]} :
                                          {word[WIDTH-1-gi:0], {gi{1'b0}}};
            end
        end
    endgenerate

    always_comb begin
        result = word;
        for (int i = 0; i <= STEP; i++) begin
            if (int'(k) == i) begin
                result = cand[i];
            end
        end
    end

endmodule

// File: rtl/shift_right_iterative.sv
// Multi-cycle SRL/SRA/ROTR/SLL unit with a start/busy/done handshake; shifts at
// most STEP bits per clock so EX can stall on Busy instead of a barrel shifter.
module shift_right_iterative
    import shift_right_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [1:0]           Mode,
    input  logic [WIDTH-1:0]     In,
    input  logic [SHAMT_W-1:0]   Shamt,
    output logic [WIDTH-1:0]     Out,
    output logic                 Busy,
    output logic                 Done
);

    localparam int KW = $clog2(STEP + 1);

    state_e               state_reg, state_next;
    logic [WIDTH-1:0]     work_reg;
    logic [WIDTH-1:0]     out_reg;
    logic [SHAMT_W-1:0]   remaining_reg;
    mode_e                mode_reg;
    logic                 sign_reg;

    logic                 accept;
    logic [KW-1:0]        k;
    logic [WIDTH-1:0]     step_result;

    // A new request is taken in IDLE and also in DONE, giving back-to-back ops.
    assign accept = Start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign k      = KW'(step_amount(remaining_reg, STEP));

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_shift_step (
        .word   (work_reg),
        .k      (k),
        .mode   (mode_reg),
        .sign   (sign_reg),
        .result (step_result)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (Start) state_next = S_SHIFT;
            S_SHIFT: if (remaining_reg == '0) state_next = S_DONE;
            S_DONE:  state_next = Start ? S_SHIFT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_reg == S_SHIFT);
        Done = (state_reg == S_DONE);
        Out  = out_reg;
    end

    // Out is written only on the transition into DONE, never mid-operation.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            work_reg      <= '0;
            out_reg       <= '0;
            remaining_reg <= '0;
            mode_reg      <= MODE_SRL;
            sign_reg      <= 1'b0;
        end else if (accept) begin
            work_reg      <= In;
            remaining_reg <= Shamt;
            mode_reg      <= mode_e'(Mode);
            sign_reg      <= In[WIDTH-1];
        end else if (state_reg == S_SHIFT) begin
            if (remaining_reg != '0) begin
                work_reg      <= step_result;
                remaining_reg <= remaining_reg - SHAMT_W'(k);
            end else begin
                out_reg       <= work_reg;
            end
        end
    end

endmodule

// File: tb/tb_shift_right_iterative.sv
// Self-checking bench for shift_right_iterative: directed scenarios plus a
// randomized sweep against an arithmetic reference model.
module tb_shift_right_iterative;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Start;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] In;
    logic [4:0]       Shamt;
    logic [WIDTH-1:0] Out;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int passed = 0;

    shift_right_iterative #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Mode  (Mode),
        .In    (In),
        .Shamt (Shamt),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input logic [1:0] m);
        logic [63:0] two;
        case (m)
            2'b00: return x >> s;
            2'b01: return 32'($signed(x) >>> s);
            2'b10: begin
                two = {x, x} >> s;
                return two[31:0];
            end
            default: return x << s;
        endcase
    endfunction

    function automatic int ref_edges(input int s);
        return (s + STEP - 1) / STEP + 1;
    endfunction

    // Issues one request (caller is 1 time unit after an edge, DUT idle or done)
    // and returns the observed result, edge count to Done and handshake flags.
    task automatic do_op(input logic [31:0] x, input int s, input logic [1:0] m,
                         output logic [31:0] o, output int edges,
                         output bit busy_ok, output bit hold_ok);
        logic [31:0] prev;
        prev    = Out;
        In      = x;
        Shamt   = 5'(s);
        Mode    = m;
        Start   = 1'b1;
        @(posedge Clk); #1;
        Start   = 1'b0;
        In      = $urandom;
        Shamt   = 5'($urandom);
        Mode    = 2'($urandom);
        edges   = -1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) busy_ok = 1'b0;
            if (Out !== prev) hold_ok = 1'b0;
            @(posedge Clk); #1;
            if (Done === 1'b1) begin
                edges = i;
                break;
            end
        end
        o = Out;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; Mode = 2'b00; In = '0; Shamt = '0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (Out !== 32'h0) $display("FAIL reset_out got=%h want=%h", Out, 32'h0); else passed++;
        checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", Busy); else passed++;
        checks++; if (Done !== 1'b0) $display("FAIL reset_done got=%b want=0", Done); else passed++;
        Rst = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_srl();
        logic [31:0] o; int e; bit b, h;
        do_op(32'h80000000, 4, 2'b00, o, e, b, h);
        $display("srl in=80000000 sh=4 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h08000000) $display("FAIL srl4_out got=%h want=%h", o, 32'h08000000); else passed++;
        checks++; if (e !== 2) $display("FAIL srl4_edges got=%0d want=2", e); else passed++;
        checks++; if (!b) $display("FAIL srl4_busy got=bad want=high_until_done"); else passed++;
        checks++; if (Busy !== 1'b0) $display("FAIL srl4_busy_at_done got=%b want=0", Busy); else passed++;
        @(posedge Clk); #1;
        checks++; if (Done !== 1'b0) $display("FAIL done_pulse got=%b want=0", Done); else passed++;
        checks++; if (Out !== 32'h08000000) $display("FAIL out_held got=%h want=%h", Out, 32'h08000000); else passed++;
        do_op(32'h80000000, 0, 2'b00, o, e, b, h);
        $display("srl in=80000000 sh=0 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h80000000) $display("FAIL srl0_out got=%h want=%h", o, 32'h80000000); else passed++;
        checks++; if (e !== 1) $display("FAIL srl0_edges got=%0d want=1", e); else passed++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] o; int e; bit b, h;
        In = 32'hFFFF0000; Shamt = 5'd31; Mode = 2'b01; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #2;
        Rst = 1'b1;
        #1;
        checks++; if (Out !== 32'h0) $display("FAIL midrst_out got=%h want=%h", Out, 32'h0); else passed++;
        checks++; if (Busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", Busy); else passed++;
        checks++; if (Done !== 1'b0) $display("FAIL midrst_done got=%b want=0", Done); else passed++;
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;
        do_op(32'hFFFF0000, 8, 2'b01, o, e, b, h);
        $display("post-reset sra in=ffff0000 sh=8 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'hFFFFFF00) $display("FAIL postrst_out got=%h want=%h", o, 32'hFFFFFF00); else passed++;
        checks++; if (e !== 3) $display("FAIL postrst_edges got=%0d want=3", e); else passed++;
    endtask

    task automatic test_sra();
        logic [31:0] o; int e; bit b, h;
        do_op(32'h80000000, 31, 2'b01, o, e, b, h);
        $display("sra in=80000000 sh=31 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'hFFFFFFFF) $display("FAIL sra_neg_out got=%h want=%h", o, 32'hFFFFFFFF); else passed++;
        checks++; if (e !== 9) $display("FAIL sra_neg_edges got=%0d want=9", e); else passed++;
        checks++; if (!h) $display("FAIL sra_out_hold got=changed want=held"); else passed++;
        do_op(32'h7FFFFFFF, 31, 2'b01, o, e, b, h);
        $display("sra in=7fffffff sh=31 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h00000000) $display("FAIL sra_pos_out got=%h want=%h", o, 32'h0); else passed++;
    endtask

    task automatic test_rotr_sll();
        logic [31:0] o; int e; bit b, h;
        do_op(32'h00000001, 1, 2'b10, o, e, b, h);
        $display("rotr in=00000001 sh=1 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h80000000) $display("FAIL rotr_out got=%h want=%h", o, 32'h80000000); else passed++;
        do_op(32'h12345678, 8, 2'b11, o, e, b, h);
        $display("sll in=12345678 sh=8 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h34567800) $display("FAIL sll_out got=%h want=%h", o, 32'h34567800); else passed++;
    endtask

    task automatic test_start_while_busy();
        int e;
        bit busy_ok;
        In = 32'hA5A5_F00F; Shamt = 5'd8; Mode = 2'b00; Start = 1'b1;
        @(posedge Clk); #1;
        In = 32'h1234_5678; Shamt = 5'd1; Mode = 2'b11;
        e = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(posedge Clk); #1;
            if (Done === 1'b1) begin
                e = i;
                break;
            end
        end
        Start = 1'b0;
        $display("busy-start in=a5a5f00f sh=8 out=%h edges=%0d", Out, e);
        checks++; if (Out !== 32'h00A5A5F0) $display("FAIL busy_start_out got=%h want=%h", Out, 32'h00A5A5F0); else passed++;
        checks++; if (e !== 3) $display("FAIL busy_start_edges got=%0d want=3", e); else passed++;
        checks++; if (!busy_ok) $display("FAIL busy_start_busy got=bad want=high"); else passed++;
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] o; int e; bit b, h;
        do_op(32'hDEADBEEF, 4, 2'b10, o, e, b, h);
        checks++; if (o !== 32'hFDEADBEE) $display("FAIL b2b_first_out got=%h want=%h", o, 32'hFDEADBEE); else passed++;
        // Still in the DONE cycle: issue the next request with no idle gap.
        do_op(32'h00000010, 4, 2'b00, o, e, b, h);
        $display("b2b in=00000010 sh=4 out=%h edges=%0d", o, e);
        checks++; if (o !== 32'h00000001) $display("FAIL b2b_out got=%h want=%h", o, 32'h1); else passed++;
        checks++; if (e !== 2) $display("FAIL b2b_edges got=%0d want=2", e); else passed++;
        checks++; if (!b) $display("FAIL b2b_no_gap got=idle_gap want=busy"); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] x, o, want;
        logic [1:0]  m;
        int          s, e;
        bit          b, h;
        for (int n = 0; n < 1000; n++) begin
            x = $urandom;
            s = $urandom_range(0, 31);
            m = 2'($urandom);
            want = ref_shift(x, s, m);
            do_op(x, s, m, o, e, b, h);
            $display("rand %0d in=%h sh=%0d mode=%0d out=%h edges=%0d", n, x, s, m, o, e);
            checks++; if (o !== want) $display("FAIL rand_out n=%0d got=%h want=%h", n, o, want); else passed++;
            checks++; if (e !== ref_edges(s)) $display("FAIL rand_edges n=%0d got=%0d want=%0d", n, e, ref_edges(s)); else passed++;
            checks++; if (!(b && h)) $display("FAIL rand_handshake n=%0d got=busy%0b/hold%0b want=1/1", n, b, h); else passed++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_reset_midop();
        test_sra();
        test_rotr_sll();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
